// File: rtl/update_knn5_udiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : update_knn5_udiv_seq
// Brief    : Sequential restoring radix-2 unsigned divider, one quotient bit
//            per enabled cycle, valid/ready handshake and global ce stall.
// Revision : 1.0 - initial release
// ============================================================================
module update_knn5_udiv_seq #(
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      div_by_zero
);

    localparam int c_CNT_W = $clog2(DIVIDEND_WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DIVIDEND_WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]                r_state;
    logic [1:0]                w_state_nx;
    logic [c_CNT_W-1:0]        r_cnt;
    logic [DIVIDEND_WIDTH-1:0] r_dvd;
    logic [DIVISOR_WIDTH-1:0]  r_dvs;
    logic                      r_zero;
    logic [DIVISOR_WIDTH:0]    r_rem;
    logic [DIVIDEND_WIDTH-1:0] r_q;

    logic                      w_accept;
    logic                      w_last;
    logic [DIVISOR_WIDTH:0]    w_rem_sh;
    logic                      w_ge;
    logic [DIVISOR_WIDTH:0]    w_rem_nx;
    logic [DIVIDEND_WIDTH-1:0] w_q_nx;

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_cnt == c_LAST);
    assign w_rem_sh = {r_rem[DIVISOR_WIDTH-1:0], r_dvd[DIVIDEND_WIDTH-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
    assign w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_dvs}) : w_rem_sh;
    assign w_q_nx   = {r_q[DIVIDEND_WIDTH-2:0], w_ge};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else if (ce) begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_IDLE:  if (in_valid) w_state_nx = c_BUSY;
            c_BUSY:  if (w_last) w_state_nx = c_DONE;
            c_DONE:  if (out_ready) w_state_nx = c_IDLE;
            default: w_state_nx = c_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_IDLE);
        out_valid = (r_state == c_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_zero      <= 1'b0;
            r_rem       <= '0;
            r_q         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (ce) begin
            if (w_accept) begin
                r_dvd  <= dividend;
                r_dvs  <= divisor;
                r_zero <= (divisor == '0);
                r_rem  <= '0;
                r_q    <= '0;
                r_cnt  <= '0;
            end else if (r_state == c_BUSY) begin
                r_dvd <= {r_dvd[DIVIDEND_WIDTH-2:0], 1'b0};
                r_rem <= w_rem_nx;
                r_q   <= w_q_nx;
                r_cnt <= r_cnt + 1'b1;
                // Divide-by-zero overrides whatever the iteration produced.
                if (w_last) begin
                    quotient    <= r_zero ? '1 : w_q_nx;
                    remainder   <= r_zero ? '0 : w_rem_nx[DIVISOR_WIDTH-1:0];
                    div_by_zero <= r_zero;
                end
            end
        end
    end

endmodule
`default_nettype wire
